// File: rtl/accelerator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : accelerator_pkg
// Description : Shared types and constants for the vector store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package accelerator_pkg;

    localparam int WIDE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } vsu_state_e;

    typedef enum logic [1:0] {
        MODE_UNIT    = 2'd0,
        MODE_STRIDED = 2'd1,
        MODE_ZERO    = 2'd2
    } stride_mode_e;

    // The reserved encoding 2'b11 is handled as 32-bit elements.
    function automatic logic [1:0] elem_log2(input logic [1:0] vsew);
        return (vsew == 2'b11) ? 2'd2 : vsew;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_be_gen.sv
`default_nettype none
// ============================================================================
// Module      : store_be_gen
// Description : Byte-lane enables, write data and beat size for one store beat.
// Revision    : 1.0 - initial release
// ============================================================================
module store_be_gen
    import accelerator_pkg::*;
(
    input  logic [1:0]              i_esz_log,
    input  logic [1:0]              i_addr_lo,
    input  stride_mode_e            i_mode,
    input  logic [4:0]              i_bytes_left,
    input  logic [3:0]              i_src_ptr,
    input  logic [3:0]              i_vl,
    input  logic [8*WIDE_BYTES-1:0] i_snapshot,
    output logic [3:0]              o_be,
    output logic [31:0]             o_wdata,
    output logic [2:0]              o_beat_bytes
);

    logic [1:0] w_first_lane;
    logic [2:0] w_esize;
    logic [2:0] w_room;
    logic [3:0] w_elem_off;
    logic [3:0] w_base;

    always_comb begin
        case (i_esz_log)
            2'd0:    w_first_lane = i_addr_lo;
            2'd1:    w_first_lane = {i_addr_lo[1], 1'b0};
            default: w_first_lane = 2'd0;
        endcase
    end

    assign w_esize = 3'd1 << i_esz_log;
    assign w_room  = 3'd4 - {1'b0, w_first_lane};

    always_comb begin
        o_beat_bytes = w_esize;
        if (i_mode == MODE_UNIT) begin
            o_beat_bytes = (i_bytes_left < {2'b00, w_room}) ? i_bytes_left[2:0] : w_room;
        end
    end

    // Snapshot index wraps modulo the 16-byte register group.
    assign w_elem_off = (i_mode == MODE_ZERO) ? ((i_vl - 4'd1) << i_esz_log) : 4'd0;
    assign w_base     = i_src_ptr + w_elem_off - {2'b00, w_first_lane};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [2:0] w_rel;
        logic [3:0] w_idx;
        assign w_rel    = 3'(k) - {1'b0, w_first_lane};
        assign o_be[k]  = (3'(k) >= {1'b0, w_first_lane}) && (w_rel < o_beat_bytes);
        assign w_idx    = w_base + 4'(k);
        assign o_wdata[8*k +: 8] = o_be[k] ? i_snapshot[8*w_idx +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/vector_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_store_unit
// Description : Streams a vector register group to memory over an OBI port.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_store_unit
    import accelerator_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic [4:0]  vl_i,
    input  logic [1:0]  vsew_i,
    input  logic        vlsu_store_i,
    input  logic        vlsu_strided_i,
    input  logic [31:0] op0_data_i,
    input  logic [31:0] op1_data_i,
    input  logic [127:0] vs_rdata_i,
    input  logic [4:0]  vr_addr_i,
    output logic        vsu_ready_o,
    output logic        vsu_done_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o
);

    vsu_state_e              r_state, w_next_state;
    logic [8*WIDE_BYTES-1:0] r_snapshot;
    logic [31:0]             r_cur_addr;
    logic [31:0]             r_stride;
    logic [3:0]              r_src_ptr;
    logic [4:0]              r_bytes_left;
    logic [1:0]              r_esz_log;
    logic [3:0]              r_vl;
    stride_mode_e            r_mode;

    logic [1:0]   w_esz_log_in;
    logic [31:0]  w_esize_in;
    logic [31:0]  w_stride_in;
    logic [6:0]   w_total_bytes;
    logic [4:0]   w_bytes_init;
    stride_mode_e w_mode_in;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [2:0]   w_beat_bytes;
    logic [4:0]   w_bytes_after;
    logic         w_last;
    logic [31:0]  w_next_addr;
    logic         w_unused_vr;

    assign w_unused_vr   = ^vr_addr_i[4:2];
    assign w_esz_log_in  = elem_log2(vsew_i);
    assign w_esize_in    = 32'd1 << w_esz_log_in;
    assign w_stride_in   = vlsu_strided_i ? op1_data_i : w_esize_in;
    assign w_total_bytes = {2'b00, vl_i} << w_esz_log_in;
    assign w_bytes_init  = (w_total_bytes > 7'(WIDE_BYTES)) ? 5'(WIDE_BYTES) : w_total_bytes[4:0];

    always_comb begin
        w_mode_in = MODE_STRIDED;
        if (w_stride_in == 32'd0) begin
            w_mode_in = MODE_ZERO;
        end else if (w_stride_in == w_esize_in) begin
            w_mode_in = MODE_UNIT;
        end
    end

    store_be_gen u_be_gen (
        .i_esz_log    (r_esz_log),
        .i_addr_lo    (r_cur_addr[1:0]),
        .i_mode       (r_mode),
        .i_bytes_left (r_bytes_left),
        .i_src_ptr    (r_src_ptr),
        .i_vl         (r_vl),
        .i_snapshot   (r_snapshot),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_beat_bytes (w_beat_bytes)
    );

    assign w_bytes_after = r_bytes_left - {2'b00, w_beat_bytes};
    assign w_last        = (r_mode == MODE_ZERO) || (w_bytes_after == 5'd0);
    // Unit stride continues at the next word; other strides realign to the element size.
    assign w_next_addr   = (r_mode == MODE_UNIT)
                         ? ({r_cur_addr[31:2], 2'b00} + 32'd4)
                         : ((r_cur_addr + r_stride) & ~((32'd1 << r_esz_log) - 32'd1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        vsu_ready_o  = 1'b0;
        vsu_done_o   = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_addr_o  = 32'd0;
        data_be_o    = 4'd0;
        data_wdata_o = 32'd0;
        case (r_state)
            IDLE: begin
                vsu_ready_o = 1'b1;
                if (vlsu_store_i) begin
                    w_next_state = (vl_i == 5'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                data_addr_o  = {r_cur_addr[31:2], 2'b00};
                data_be_o    = w_be;
                data_wdata_o = w_wdata;
                if (data_gnt_i) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (data_rvalid_i) begin
                    w_next_state = w_last ? DONE : REQ;
                end
            end
            DONE: begin
                vsu_done_o   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_snapshot   <= '0;
            r_cur_addr   <= 32'd0;
            r_stride     <= 32'd0;
            r_src_ptr    <= 4'd0;
            r_bytes_left <= 5'd0;
            r_esz_log    <= 2'd0;
            r_vl         <= 4'd0;
            r_mode       <= MODE_UNIT;
        end else if (r_state == IDLE && vlsu_store_i) begin
            r_snapshot   <= vs_rdata_i;
            r_cur_addr   <= op0_data_i;
            r_stride     <= w_stride_in;
            r_src_ptr    <= {vr_addr_i[1:0], 2'b00};
            r_bytes_left <= w_bytes_init;
            r_esz_log    <= w_esz_log_in;
            r_vl         <= vl_i[3:0];
            r_mode       <= w_mode_in;
        end else if (r_state == RESP && data_rvalid_i) begin
            r_bytes_left <= w_bytes_after;
            r_src_ptr    <= r_src_ptr + {1'b0, w_beat_bytes};
            r_cur_addr   <= w_next_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_store_unit
// Description : Directed scoreboard bench for vector_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_store_unit;

    logic         clk            = 1'b0;
    logic         n_reset        = 1'b1;
    logic [4:0]   vl_i           = '0;
    logic [1:0]   vsew_i         = '0;
    logic         vlsu_store_i   = 1'b0;
    logic         vlsu_strided_i = 1'b0;
    logic [31:0]  op0_data_i     = '0;
    logic [31:0]  op1_data_i     = '0;
    logic [127:0] vs_rdata_i     = '0;
    logic [4:0]   vr_addr_i      = '0;
    logic         data_gnt_i     = 1'b0;
    logic         data_rvalid_i  = 1'b0;
    logic         vsu_ready_o, vsu_done_o, data_req_o, data_we_o;
    logic [31:0]  data_addr_o, data_wdata_o;
    logic [3:0]   data_be_o;

    vector_store_unit dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .vl_i           (vl_i),
        .vsew_i         (vsew_i),
        .vlsu_store_i   (vlsu_store_i),
        .vlsu_strided_i (vlsu_strided_i),
        .op0_data_i     (op0_data_i),
        .op1_data_i     (op1_data_i),
        .vs_rdata_i     (vs_rdata_i),
        .vr_addr_i      (vr_addr_i),
        .vsu_ready_o    (vsu_ready_o),
        .vsu_done_o     (vsu_done_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t        sbq[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input int i);
        return snap[i*8 +: 8];
    endfunction

    task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = wd;
        sbq.push_back(b);
    endtask

    task automatic new_snap();
        snap = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Issues one store, acts as the memory (grant/response delays) and checks every requested beat.
    task automatic do_store(input logic [4:0] vl, input logic [1:0] vsew, input logic strided,
                            input logic [31:0] base, input logic [31:0] stride, input logic [4:0] vr,
                            input int gnt_dly, input int rv_dly, input bit poke, input int exp_done);
        int cyc, wait_g, wait_r, ndone, done_cyc;
        bit resp;
        cyc = 0; wait_g = 0; wait_r = 0; ndone = 0; done_cyc = -1; resp = 1'b0;
        @(negedge clk);
        vl_i = vl; vsew_i = vsew; vlsu_strided_i = strided; op0_data_i = base;
        op1_data_i = stride; vr_addr_i = vr; vs_rdata_i = snap; vlsu_store_i = 1'b1;
        while (ndone == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            vlsu_store_i   = poke ? 1'((cyc & 1)) : 1'b0;
            vl_i           = 5'($urandom);
            vsew_i         = 2'($urandom);
            vlsu_strided_i = 1'($urandom);
            op0_data_i     = $urandom;
            op1_data_i     = $urandom;
            vr_addr_i      = 5'($urandom);
            vs_rdata_i     = {$urandom, $urandom, $urandom, $urandom};
            data_gnt_i     = 1'b0;
            data_rvalid_i  = poke ? 1'($urandom) : 1'b0;
            if (vsu_done_o) begin
                ndone++;
                done_cyc = cyc;
            end else if (resp) begin
                check("resp_req_low", data_req_o, 0);
                if (wait_r >= rv_dly) begin
                    data_rvalid_i = 1'b1;
                    resp = 1'b0;
                end else begin
                    data_rvalid_i = 1'b0;
                    wait_r++;
                end
            end else if (data_req_o) begin
                if (sbq.size() == 0) begin
                    check("unexpected_req", 32'(sbq.size()), 1);
                end else begin
                    check("beat_addr",  data_addr_o,  sbq[0].addr);
                    check("beat_be",    data_be_o,    sbq[0].be);
                    check("beat_wdata", data_wdata_o, sbq[0].wdata);
                    check("beat_we",    data_we_o,    1);
                end
                if (wait_g >= gnt_dly) begin
                    data_gnt_i = 1'b1;
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    resp = 1'b1; wait_r = 0; wait_g = 0;
                end else begin
                    wait_g++;
                end
            end
        end
        vlsu_store_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        check("done_count", ndone, 1);
        if (exp_done > 0) check("done_latency", done_cyc, exp_done);
        check("beats_missing", 32'(sbq.size()), 0);
        sbq.delete();
        @(negedge clk);
        check("done_width", vsu_done_o, 0);
        check("ready_after", vsu_ready_o, 1);
        check("req_after", data_req_o, 0);
    endtask

    initial begin
        #1 n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_ready", vsu_ready_o, 1);
        check("rst_done",  vsu_done_o, 0);
        check("rst_req",   data_req_o, 0);
        check("rst_we",    data_we_o, 0);
        check("rst_be",    data_be_o, 0);
        check("rst_wdata", data_wdata_o, 0);
        check("rst_addr",  data_addr_o, 0);

        // 8b unit stride, one full word, grant immediately
        new_snap();
        push(32'h100, 4'b1111, {sb(3), sb(2), sb(1), sb(0)});
        do_store(5'd4, 2'b00, 1'b0, 32'h100, 32'h0, 5'd0, 0, 0, 1'b0, 3);

        // 16b unit stride from a half-word offset
        new_snap();
        push(32'h200, 4'b1100, {sb(1), sb(0), 16'h0});
        push(32'h204, 4'b1111, {sb(5), sb(4), sb(3), sb(2)});
        do_store(5'd3, 2'b01, 1'b0, 32'h202, 32'h0, 5'd0, 0, 0, 1'b0, 0);

        // 32b stride 8 starting from word 2 of the register group
        new_snap();
        push(32'h1000, 4'b1111, snap[95:64]);
        push(32'h1008, 4'b1111, snap[127:96]);
        do_store(5'd2, 2'b10, 1'b1, 32'h1000, 32'd8, 5'd2, 0, 1, 1'b0, 0);

        // stride 0 writes only the last element
        new_snap();
        push(32'h40, 4'b1000, {sb(4), 24'h0});
        do_store(5'd5, 2'b00, 1'b1, 32'h43, 32'd0, 5'd0, 1, 0, 1'b0, 0);

        // slow grant/response with stray starts and early rvalid; 16b stride 6
        new_snap();
        push(32'h30, 4'b0011, {16'h0, sb(1), sb(0)});
        push(32'h34, 4'b1100, {sb(3), sb(2), 16'h0});
        push(32'h3C, 4'b0011, {16'h0, sb(5), sb(4)});
        push(32'h40, 4'b1100, {sb(7), sb(6), 16'h0});
        do_store(5'd4, 2'b01, 1'b1, 32'h31, 32'd6, 5'd0, 3, 2, 1'b1, 0);

        // 8b unit stride wrapping through address zero, source word 1
        new_snap();
        push(32'hFFFF_FFFC, 4'b1100, {sb(5), sb(4), 16'h0});
        push(32'h0000_0000, 4'b1111, {sb(9), sb(8), sb(7), sb(6)});
        do_store(5'd6, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd1, 2, 1, 1'b0, 0);

        // 32b, vl*size exceeds the register group: clamped to 16 bytes
        new_snap();
        push(32'h20, 4'b1111, snap[31:0]);
        push(32'h24, 4'b1111, snap[63:32]);
        push(32'h28, 4'b1111, snap[95:64]);
        push(32'h2C, 4'b1111, snap[127:96]);
        do_store(5'd7, 2'b10, 1'b0, 32'h20, 32'h0, 5'd0, 0, 0, 1'b0, 0);

        // 8b unit stride limited by remaining bytes within a word
        new_snap();
        push(32'h0, 4'b1110, {sb(2), sb(1), sb(0), 8'h0});
        do_store(5'd3, 2'b00, 1'b0, 32'h1, 32'h0, 5'd0, 0, 0, 1'b0, 0);
        new_snap();
        push(32'h0, 4'b1111, {sb(3), sb(2), sb(1), sb(0)});
        push(32'h4, 4'b0011, {16'h0, sb(5), sb(4)});
        do_store(5'd6, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1, 3, 1'b1, 0);

        // asynchronous reset while in RESP
        @(negedge clk);
        vl_i = 5'd4; vsew_i = 2'b00; vlsu_strided_i = 1'b0; op0_data_i = 32'h100; vlsu_store_i = 1'b1;
        @(negedge clk);
        vlsu_store_i = 1'b0;
        check("rr_req", data_req_o, 1);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        check("rr_resp_ready", vsu_ready_o, 0);
        #2 n_reset = 1'b0;
        #1;
        check("rr_ready", vsu_ready_o, 1);
        check("rr_req_low", data_req_o, 0);
        @(negedge clk);
        n_reset = 1'b1;

        // asynchronous reset while requesting drops the request at once
        @(negedge clk);
        vlsu_store_i = 1'b1;
        @(negedge clk);
        vlsu_store_i = 1'b0;
        check("rq_req", data_req_o, 1);
        #2 n_reset = 1'b0;
        #1;
        check("rq_req_low", data_req_o, 0);
        check("rq_addr_zero", data_addr_o, 0);
        check("rq_be_zero", data_be_o, 0);
        @(negedge clk);
        n_reset = 1'b1;

        // vl = 0: no request, done after one cycle
        @(negedge clk);
        vl_i = 5'd0; vlsu_store_i = 1'b1;
        @(negedge clk);
        vlsu_store_i = 1'b0;
        check("vl0_done", vsu_done_o, 1);
        check("vl0_req", data_req_o, 0);
        @(negedge clk);
        check("vl0_done_width", vsu_done_o, 0);
        check("vl0_ready", vsu_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vector_store_unit.md
VECTOR_STORE_UNIT -- requirements
Module: vector_store_unit

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first; one clock, reset asynchronous active-low:
- clk  in  1  sole clock.
- n_reset  in  1  async active-low reset.
- vl_i  in  5  element count.
- vsew_i  in  2  00=8b, 01=16b, 10=32b.
- vlsu_store_i  in  1  start pulse.
- vlsu_strided_i  in  1  use op1 stride.
- op0_data_i  in  32  base address.
- op1_data_i  in  32  byte stride.
- vs_rdata_i  in  128  wide register-group read data.
- vr_addr_i  in  5  source register; bits [1:0] select the start word.
- vsu_ready_o  out  1  idle, start accepted.
- vsu_done_o  out  1  completion pulse.
- data_req_o  out  1  OBI request.
- data_gnt_i  in  1  OBI grant.
- data_rvalid_i  in  1  OBI response.
- data_addr_o  out  32  word-aligned address.
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  write data.

Function
REQ-002 SHALL use states IDLE, REQ, RESP, DONE.
REQ-003 IDLE: vsu_ready_o=1; on vlsu_store_i, latch vs_rdata_i into a 128-bit snapshot, op0_data_i into cur_addr, {vr_addr_i[1:0],2'b00} into src_ptr, and min(vl_i<<vsew_i,16) into bytes_left; go to REQ, or to DONE if vl_i=0.
REQ-004 Effective stride SHALL be op1_data_i when vlsu_strided_i=1, else 1<<vsew_i.
REQ-005 REQ: data_req_o=1 and data_we_o=1; addr/be/wdata held stable until data_gnt_i=1, then go to RESP.
REQ-006 RESP: outputs idle; on data_rvalid_i, subtract beat bytes from bytes_left, add them to src_ptr, advance cur_addr; go to DONE if bytes_left reaches 0, else REQ. rvalid SHALL be ignored outside RESP.
REQ-007 DONE: vsu_done_o=1 for exactly one cycle, then IDLE.
REQ-008 data_addr_o SHALL be {cur_addr[31:2],2'b00}.
REQ-009 Lane alignment: first lane = cur_addr[1:0] (8b), {cur_addr[1],0} (16b), 0 (32b).
REQ-010 Unit stride (stride == element size): enable lanes from the first lane to lane 3, limited to bytes_left. Next cur_addr SHALL be the word address + 4.
REQ-011 Other non-zero stride: one element per beat at the first lane. Next cur_addr SHALL be cur_addr+stride, with low bits masked to element alignment.
REQ-012 Stride 0: one beat writing element vl_i-1 only, then DONE.
REQ-013 data_wdata_o byte k SHALL equal snapshot byte (src_ptr + k - first_lane) for enabled lanes and 0 otherwise (element vl_i-1 for stride 0).
REQ-014 vlsu_store_i outside IDLE SHALL be ignored.
REQ-015 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around allowed).

Reset
REQ-016 Assertion of n_reset SHALL asynchronously force IDLE, including mid-transaction.
REQ-017 Reset values: data_req_o=0, data_we_o=0, data_be_o=0, data_wdata_o=0, data_addr_o=0, vsu_done_o=0, vsu_ready_o=1 (once released); counters and snapshot cleared.

Structure
REQ-018 The state enum and the constant WIDE_BYTES=16 SHALL reside in accelerator_pkg.
REQ-019 Lane/byte-enable generation SHALL be one combinational sub-module, store_be_gen.

Verification
REQ-020 8b, vl=4, unit, base 0x100, gnt same cycle -> one beat addr 0x100, be 1111, wdata = snapshot bytes 3..0; done 3 cycles after start.
REQ-021 16b, vl=3, unit, base 0x202 -> beats (0x200, be 1100), (0x204, be 1111); done pulse once.
REQ-022 32b, vl=2, stride 8, base 0x1000, vr_addr[1:0]=2 -> beats 0x1000 then 0x1008, both be 1111, data from snapshot words 2 and 3.
REQ-023 8b, vl=5, stride 0, base 0x43 -> single beat addr 0x40, be 1000, byte 3 = element 4.
REQ-024 gnt delayed 3 cycles, rvalid delayed 2 cycles -> req/addr/be/wdata stable throughout; start pulses during the operation are ignored.
REQ-025 n_reset asserted in RESP -> data_req_o=0 immediately; vl=0 start -> no request, done after 1 cycle.
